// File: rtl/param_counter.sv
// Modulo-N up/down counter with synchronous clear, clamped parallel load and a
// wrap-or-saturate mode. It provides a combinational terminal count and a registered wrap pulse.
module param_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data,
    output logic             tc,
    output logic             wrap
);

    // One spare bit keeps the MAX_COUNT compare and the increment free of overflow.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } op_e;

    op_e              op;
    logic [WIDTH:0]   data_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   data_inc;
    logic [WIDTH:0]   data_dec;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] data_nxt;
    logic             wrap_nxt;

    assign data_ext = {1'b0, data};
    assign load_ext = {1'b0, load_val};
    assign data_inc = data_ext + ONE_EXT;
    assign data_dec = data_ext - ONE_EXT;
    assign at_max   = (data_ext >= MAX_EXT);
    assign at_zero  = (data_ext == '0);

    assign tc = up_dn ? at_max : at_zero;

    // Clear beats load, and load beats counting.
    always_comb begin
        if (clear)
            op = OP_CLEAR;
        else if (load)
            op = OP_LOAD;
        else if (enable)
            op = up_dn ? OP_UP : OP_DOWN;
        else
            op = OP_HOLD;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        data_nxt = data;
        wrap_nxt = 1'b0;
        unique case (op)
            OP_CLEAR: data_nxt = '0;
            OP_LOAD:  data_nxt = (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
            OP_UP: begin
                if (!at_max) begin
                    data_nxt = data_inc[WIDTH-1:0];
                end else if (!SATURATE) begin
                    data_nxt = '0;
                    wrap_nxt = 1'b1;
                end
            end
            OP_DOWN: begin
                if (!at_zero) begin
                    data_nxt = data_dec[WIDTH-1:0];
                end else if (!SATURATE) begin
                    data_nxt = MAX_EXT[WIDTH-1:0];
                    wrap_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
            wrap <= 1'b0;
        end else begin
            data <= data_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter with three instances sharing one stimulus:
// a full-range wrapping counter, a modulo-10 wrapping counter, and a modulo-10 saturating counter.
module tb_param_counter;

    localparam int N = 3;
    localparam int MAXV[N] = '{15, 9, 9};
    localparam bit SATV[N] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       up_dn = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] data_o[N];
    logic       tc_o[N];
    logic       wrap_o[N];

    int checks = 0;
    int errors = 0;

    int mdl_data[N] = '{0, 0, 0};
    bit mdl_wrap[N] = '{0, 0, 0};

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4)) u_full (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .data(data_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0])
    );
    param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_mod (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .data(data_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1])
    );
    param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .data(data_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2])
    );

    always @(posedge clk) begin
        if (reset_n === 1'b1 && $isunknown({enable, up_dn, clear, load})) begin
            errors++;
            $display("FAIL x_on_controls: got %b required known values", {enable, up_dn, clear, load});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: modular arithmetic over the range 0..max.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            mdl_wrap[k] = 1'b0;
            if (!reset_n || clear) begin
                mdl_data[k] = 0;
            end else if (load) begin
                mdl_data[k] = (int'(load_val) > MAXV[k]) ? MAXV[k] : int'(load_val);
            end else if (enable && up_dn) begin
                if (SATV[k]) begin
                    mdl_data[k] = (mdl_data[k] + 1 > MAXV[k]) ? MAXV[k] : mdl_data[k] + 1;
                end else begin
                    mdl_wrap[k] = (mdl_data[k] + 1 > MAXV[k]);
                    mdl_data[k] = (mdl_data[k] + 1) % (MAXV[k] + 1);
                end
            end else if (enable) begin
                if (SATV[k]) begin
                    mdl_data[k] = (mdl_data[k] - 1 < 0) ? 0 : mdl_data[k] - 1;
                end else begin
                    mdl_wrap[k] = (mdl_data[k] - 1 < 0);
                    mdl_data[k] = (mdl_data[k] + MAXV[k]) % (MAXV[k] + 1);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("model_data[%0d]", k), 32'(data_o[k]), 32'(mdl_data[k]));
            check($sformatf("model_wrap[%0d]", k), 32'(wrap_o[k]), 32'(mdl_wrap[k]));
            check($sformatf("model_tc[%0d]", k), 32'(tc_o[k]),
                  32'(up_dn ? (mdl_data[k] == MAXV[k]) : (mdl_data[k] == 0)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_ctrl(input bit c, input bit l, input bit e, input bit u, input logic [3:0] v);
        clear = c; load = l; enable = e; up_dn = u; load_val = v;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 reset_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            mdl_data[k] = 0;
            mdl_wrap[k] = 1'b0;
        end
        #1;
        check({tag, "_data_full"}, 32'(data_o[0]), 32'd0);
        check({tag, "_data_mod"}, 32'(data_o[1]), 32'd0);
        check({tag, "_wrap_full"}, 32'(wrap_o[0]), 32'd0);
        set_ctrl(0, 0, 0, 1, 4'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit         c;
        bit         l;
        bit         e;
        bit         u;
        logic [3:0] v;
        int         exp_full;
        int         exp_mod;
        int         exp_sat;
        logic [2:0] exp_wrap;
    } vec_t;

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1, 0, 0, 1, 4'd0,  0,  0, 0, 3'b000};
        vecs[1] = '{0, 1, 1, 1, 4'd5,  5,  5, 5, 3'b000};
        vecs[2] = '{0, 0, 1, 1, 4'd0,  6,  6, 6, 3'b000};
        vecs[3] = '{0, 1, 0, 1, 4'd14, 14, 9, 9, 3'b000};
        vecs[4] = '{0, 0, 1, 1, 4'd0,  15, 0, 9, 3'b010};
        vecs[5] = '{1, 1, 1, 1, 4'd3,  0,  0, 0, 3'b000};
        vecs[6] = '{0, 0, 1, 0, 4'd0,  15, 9, 0, 3'b011};
        vecs[7] = '{0, 1, 0, 0, 4'd15, 15, 9, 9, 3'b000};
        vecs[8] = '{0, 0, 0, 1, 4'd0,  15, 9, 9, 3'b000};
        vecs[9] = '{0, 0, 1, 0, 4'd0,  14, 8, 8, 3'b000};

        // Reset held for 10 cycles, then released with enable low.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_data", 32'(data_o[0]), 32'd0);
            check("reset_wrap", 32'(wrap_o[0]), 32'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_data", 32'(data_o[0]), 32'd0);
        end

        // Up count through the natural rollover.
        set_ctrl(0, 0, 1, 1, 4'd0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("up_data", 32'(data_o[0]), 32'(i % 16));
            check("up_wrap", 32'(wrap_o[0]), 32'(i == 16));
            check("up_tc", 32'(tc_o[0]), 32'((i % 16) == 15));
            if (i == 12) begin
                check("sat_up_data", 32'(data_o[2]), 32'd9);
                check("sat_up_tc", 32'(tc_o[2]), 32'd1);
            end
        end

        // Asynchronous reset mid-count at 7, then during a wrap pulse.
        set_ctrl(1, 0, 0, 1, 4'd0);
        tick();
        set_ctrl(0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_data", 32'(data_o[0]), 32'd7);
        async_reset_pulse("midcount_reset");
        set_ctrl(0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 16; i++) tick();
        check("pre_reset_wrap", 32'(wrap_o[0]), 32'd1);
        async_reset_pulse("midwrap_reset");

        // Down count in the modulo-10 range.
        set_ctrl(1, 0, 0, 0, 4'd0);
        tick();
        set_ctrl(0, 0, 1, 0, 4'd0);
        for (int i = 1; i <= 22; i++) begin
            tick();
            check("down_data", 32'(data_o[1]), 32'((10 - i % 10) % 10));
            check("down_wrap", 32'(wrap_o[1]), 32'((i % 10) == 1));
            check("down_in_range", 32'(data_o[1] <= 4'd9), 32'd1);
        end

        // Saturating counter: stop at 9, turn around, stop at 0.
        set_ctrl(1, 0, 0, 1, 4'd0);
        tick();
        set_ctrl(0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 12; i++) tick();
        check("sat_top_data", 32'(data_o[2]), 32'd9);
        check("sat_top_wrap", 32'(wrap_o[2]), 32'd0);
        check("sat_top_tc", 32'(tc_o[2]), 32'd1);
        up_dn = 1'b0;
        tick();
        check("sat_turn_data", 32'(data_o[2]), 32'd8);
        for (int i = 0; i < 10; i++) tick();
        check("sat_bottom_data", 32'(data_o[2]), 32'd0);
        check("sat_bottom_tc", 32'(tc_o[2]), 32'd1);

        // Priority and clamped-load vectors.
        foreach (vecs[i]) begin
            set_ctrl(vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].v);
            tick();
            check($sformatf("vec%0d_full", i), 32'(data_o[0]), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_mod", i), 32'(data_o[1]), 32'(vecs[i].exp_mod));
            check($sformatf("vec%0d_sat", i), 32'(data_o[2]), 32'(vecs[i].exp_sat));
            check($sformatf("vec%0d_wrap", i), 32'({wrap_o[2], wrap_o[1], wrap_o[0]}),
                  32'(vecs[i].exp_wrap));
        end

        // Load at the top of the range while counting up suppresses the wrap.
        set_ctrl(0, 1, 0, 1, 4'd15);
        tick();
        set_ctrl(0, 1, 1, 1, 4'd2);
        tick();
        check("load_vs_wrap_data", 32'(data_o[0]), 32'd2);
        check("load_vs_wrap_wrap", 32'(wrap_o[0]), 32'd0);
        set_ctrl(0, 0, 0, 1, 4'd0);
        tick();
        check("load_vs_wrap_after", 32'(wrap_o[0]), 32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            set_ctrl($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
Parametrised successor to the team's fixed 4-bit enable counter. It is a modulo-N up/down counter with synchronous clear, parallel load, and wrap-or-saturate mode. It also provides terminal-count and wrap-event outputs. It is the standard count/timer primitive for the testbench and datapath blocks in this codebase.

Parameters:
WIDTH, 4, counter width in bits (>=1)
MAX_COUNT, 2**WIDTH-1, highest count value; count range 0..MAX_COUNT; must be <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  count qualifier; one step per clk edge while high
up_dn  input  1  1 = count up, 0 = count down
clear  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
data  output  WIDTH  registered count value
tc  output  1  terminal count, combinational: data is at the range end for the current direction
wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge

Behaviour:
- Reset (reset_n low, asynchronous, no clock needed): data = 0, wrap = 0. Reset is released synchronously by the system.
- Per rising clk edge, the first matching rule applies:
  1. clear=1: data <= 0; wrap <= 0.
  2. load=1: data <= min(load_val, MAX_COUNT); wrap <= 0. An out-of-range load clamps to MAX_COUNT.
  3. enable=1, up_dn=1:
     - data < MAX_COUNT: data <= data+1; wrap <= 0.
     - data == MAX_COUNT, SATURATE=0: data <= 0; wrap <= 1.
     - data == MAX_COUNT, SATURATE=1: data holds; wrap <= 0.
  4. enable=1, up_dn=0:
     - data > 0: data <= data-1; wrap <= 0.
     - data == 0, SATURATE=0: data <= MAX_COUNT; wrap <= 1.
     - data == 0, SATURATE=1: data holds; wrap <= 0.
  5. Otherwise: data holds; wrap <= 0.
- clear and load override enable. clear overrides load.
- tc = (up_dn ? data==MAX_COUNT : data==0). tc does not depend on enable, clear, load or SATURATE.
- Latency: data updates on the same edge the controls are sampled. wrap asserts for exactly one cycle after the wrapping edge.
- Arithmetic:
  - Internal compare and increment use WIDTH+1 bits.
  - With MAX_COUNT = 2**WIDTH-1 the wrap is the natural rollover.
  - With MAX_COUNT < 2**WIDTH-1, data never exceeds MAX_COUNT.
- up_dn may change on any cycle. The direction takes effect on the same edge with no extra latency.
- Asserting reset_n low mid-count forces data=0 and wrap=0 immediately, including mid-wrap-pulse.
- X/Z on enable, up_dn, clear or load while reset_n is high is illegal. The bench asserts this is never driven.

Test Plan:
1. Reset/hold (WIDTH=4 defaults): reset_n=0 for 10 cycles, then release with enable=0 for 5 cycles -> data=0, wrap=0 throughout. Pull reset_n low asynchronously mid-count at data=7 -> data=0 before the next edge.
2. Up wrap (WIDTH=4, MAX_COUNT=15):
   - Stimulus: enable=1, up_dn=1 for 17 edges from 0.
   - Response: data steps 0..15 then 0, 1. tc=1 only while data=15. wrap=1 exactly in the cycle after 15->0.
3. Down wrap, modulo (WIDTH=4, MAX_COUNT=9):
   - Stimulus: from 0, enable=1, up_dn=0.
   - Response: data goes 9, 8, ..., 0, 9. wrap pulses after each 0->9. Data never exceeds 9.
4. Saturate (SATURATE=1, MAX_COUNT=9):
   - Count up 12 edges from 0 -> data stops at 9, wrap stays 0, tc=1.
   - Flip up_dn=0 -> data=8 on the next edge.
   - Count down past 0 -> data holds 0.
5. Priority/load (MAX_COUNT=9):
   - Stimulus: enable=1, load=1, load_val=5 on the same edge.
   - Response: data=5, not 6. Next edge: data=6.
   - load_val=14 -> data=9 (clamped).
   - clear=1 with load=1, load_val=3 -> data=0.
6. Wrap cleared by load (MAX_COUNT=15): at data=15, up, assert load=1, load_val=2 together with enable -> data=2, wrap=0 on the following cycle.
